// File: rtl/reg_file_sequencer.sv
// reg_file_sequencer
//   Multi-cycle sequencer between decode/control and a dual-port register
//   file. Takes one request at a time over valid/ready, then performs a
//   register-pair read, a byte or word writeback, or a pointer-pair fetch
//   with optional post-increment / pre-decrement write-back.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid / req_ready           request handshake (ready only in IDLE)
//   req_op, req_rd, req_rr,
//   req_ptr, req_ptr_mode,
//   req_wdata                       request fields, latched on accept
//   rsp_valid                       one-cycle completion pulse
//   rsp_rd_data, rsp_rr_data        READ results, held to next completion
//   rsp_addr                        PTR effective address, held likewise
//   busy                            sequencer not IDLE
//   rd_* / rr_*                     the two register-file ports
module reg_file_sequencer #(
  parameter int DATA_WIDTH    = 8,
  parameter int R_ADDR_WIDTH  = 5,
  parameter int PTR_COUNT     = 3,
  parameter int PTR_BASE      = 26,
  parameter int PTR_SEL_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [2:0]                req_op,
  input  logic [R_ADDR_WIDTH-1:0]   req_rd,
  input  logic [R_ADDR_WIDTH-1:0]   req_rr,
  input  logic [PTR_SEL_WIDTH-1:0]  req_ptr,
  input  logic [1:0]                req_ptr_mode,
  input  logic [2*DATA_WIDTH-1:0]   req_wdata,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rd_data,
  output logic [DATA_WIDTH-1:0]     rsp_rr_data,
  output logic [2*DATA_WIDTH-1:0]   rsp_addr,
  output logic                      busy,
  output logic [R_ADDR_WIDTH-1:0]   rd_addr,
  output logic [R_ADDR_WIDTH-1:0]   rr_addr,
  output logic [DATA_WIDTH-1:0]     rd_wdata,
  output logic [DATA_WIDTH-1:0]     rr_wdata,
  input  logic [DATA_WIDTH-1:0]     rd_rdata,
  input  logic [DATA_WIDTH-1:0]     rr_rdata,
  output logic                      rd_cs,
  output logic                      rr_cs,
  output logic                      rd_we,
  output logic                      rr_we
);

  localparam int PW = 2 * DATA_WIDTH;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_READ   = 3'd1;
  localparam logic [2:0] ST_WRITE  = 3'd2;
  localparam logic [2:0] ST_PTR_RD = 3'd3;
  localparam logic [2:0] ST_PTR_WB = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_READ   = 3'd1;
  localparam logic [2:0] OP_WBYTE  = 3'd2;
  localparam logic [2:0] OP_WWORD  = 3'd3;
  localparam logic [2:0] OP_PTR    = 3'd4;

  localparam logic [1:0] MODE_INC  = 2'd1;
  localparam logic [1:0] MODE_DEC  = 2'd2;

  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [2:0]               state_q, state_d;
  logic [2:0]               op_q, op_d;
  logic [R_ADDR_WIDTH-1:0]  rd_q, rd_d;
  logic [R_ADDR_WIDTH-1:0]  rr_q, rr_d;
  logic [PTR_SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [1:0]               mode_q, mode_d;
  logic [PW-1:0]            wdata_q, wdata_d;
  logic [PW-1:0]            eff_q, eff_d;
  logic [PW-1:0]            newp_q, newp_d;
  logic [DATA_WIDTH-1:0]    rsp_rd_data_q, rsp_rd_data_d;
  logic [DATA_WIDTH-1:0]    rsp_rr_data_q, rsp_rr_data_d;
  logic [PW-1:0]            rsp_addr_q, rsp_addr_d;

  logic [R_ADDR_WIDTH-1:0]  pair_lo_s;
  logic [R_ADDR_WIDTH-1:0]  pair_hi_s;
  logic [PW-1:0]            ptr_p_s;
  logic [PW-1:0]            eff_s;
  logic [PW-1:0]            newp_s;

  // Register address of the low byte of a pointer pair.
  function automatic logic [R_ADDR_WIDTH-1:0] pair_lo_addr(
    input logic [PTR_SEL_WIDTH-1:0] sel
  );
    return R_ADDR_WIDTH'(PTR_BASE) + R_ADDR_WIDTH'({sel, 1'b0});
  endfunction

  assign req_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign rsp_valid   = (state_q == ST_DONE);
  assign rsp_rd_data = rsp_rd_data_q;
  assign rsp_rr_data = rsp_rr_data_q;
  assign rsp_addr    = rsp_addr_q;

  // Pointer arithmetic on the pair being read this cycle; wraps modulo 2^PW.
  always_comb begin
    pair_lo_s = pair_lo_addr(ptr_q);
    pair_hi_s = pair_lo_s + R_ADDR_WIDTH'(1);
    ptr_p_s   = {rr_rdata, rd_rdata};
    if (mode_q == MODE_DEC) begin
      eff_s  = ptr_p_s - PTR_ONE;
      newp_s = ptr_p_s - PTR_ONE;
    end else if (mode_q == MODE_INC) begin
      eff_s  = ptr_p_s;
      newp_s = ptr_p_s + PTR_ONE;
    end else begin
      eff_s  = ptr_p_s;
      newp_s = ptr_p_s;
    end
  end

  // Next-state, request latching and response capture.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    rd_d          = rd_q;
    rr_d          = rr_q;
    ptr_d         = ptr_q;
    mode_d        = mode_q;
    wdata_d       = wdata_q;
    eff_d         = eff_q;
    newp_d        = newp_q;
    rsp_rd_data_d = rsp_rd_data_q;
    rsp_rr_data_d = rsp_rr_data_q;
    rsp_addr_d    = rsp_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          rd_d    = req_rd;
          rr_d    = req_rr;
          ptr_d   = req_ptr;
          mode_d  = req_ptr_mode;
          wdata_d = req_wdata;
          case (req_op)
            OP_READ:  state_d = ST_READ;
            OP_WBYTE: state_d = ST_WRITE;
            OP_WWORD: state_d = ST_WRITE;
            OP_PTR: begin
              // Out-of-range pair select completes at once with address 0.
              if (int'(req_ptr) >= PTR_COUNT) begin
                state_d    = ST_DONE;
                rsp_addr_d = '0;
              end else begin
                state_d    = ST_PTR_RD;
              end
            end
            default:  state_d = ST_DONE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        rsp_rd_data_d = rd_rdata;
        rsp_rr_data_d = rr_rdata;
        state_d       = ST_DONE;
      end
      ST_WRITE: begin
        state_d = ST_DONE;
      end
      ST_PTR_RD: begin
        eff_d  = eff_s;
        newp_d = newp_s;
        if ((mode_q == MODE_INC) || (mode_q == MODE_DEC)) begin
          state_d = ST_PTR_WB;
        end else begin
          state_d    = ST_DONE;
          rsp_addr_d = eff_s;
        end
      end
      ST_PTR_WB: begin
        rsp_addr_d = eff_q;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register-file port controls, decoded straight from state so that an
  // asynchronous reset removes cs/we within the same cycle.
  always_comb begin
    rd_addr  = '0;
    rr_addr  = '0;
    rd_wdata = '0;
    rr_wdata = '0;
    rd_cs    = 1'b0;
    rr_cs    = 1'b0;
    rd_we    = 1'b0;
    rr_we    = 1'b0;
    case (state_q)
      ST_READ: begin
        rd_addr = rd_q;
        rr_addr = rr_q;
        rd_cs   = 1'b1;
        rr_cs   = 1'b1;
      end
      ST_WRITE: begin
        if (op_q == OP_WWORD) begin
          // Word writes target an aligned even/odd register pair.
          rd_addr  = {rd_q[R_ADDR_WIDTH-1:1], 1'b0};
          rr_addr  = {rd_q[R_ADDR_WIDTH-1:1], 1'b1};
          rd_wdata = wdata_q[DATA_WIDTH-1:0];
          rr_wdata = wdata_q[PW-1:DATA_WIDTH];
          rd_cs    = 1'b1;
          rr_cs    = 1'b1;
          rd_we    = 1'b1;
          rr_we    = 1'b1;
        end else begin
          rd_addr  = rd_q;
          rd_wdata = wdata_q[DATA_WIDTH-1:0];
          rd_cs    = 1'b1;
          rd_we    = 1'b1;
        end
      end
      ST_PTR_RD: begin
        rd_addr = pair_lo_s;
        rr_addr = pair_hi_s;
        rd_cs   = 1'b1;
        rr_cs   = 1'b1;
      end
      ST_PTR_WB: begin
        rd_addr  = pair_lo_s;
        rr_addr  = pair_hi_s;
        rd_wdata = newp_q[DATA_WIDTH-1:0];
        rr_wdata = newp_q[PW-1:DATA_WIDTH];
        rd_cs    = 1'b1;
        rr_cs    = 1'b1;
        rd_we    = 1'b1;
        rr_we    = 1'b1;
      end
      default: begin
        rd_cs = 1'b0;
      end
    endcase
  end

  // State and datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_NOP;
      rd_q          <= '0;
      rr_q          <= '0;
      ptr_q         <= '0;
      mode_q        <= 2'd0;
      wdata_q       <= '0;
      eff_q         <= '0;
      newp_q        <= '0;
      rsp_rd_data_q <= '0;
      rsp_rr_data_q <= '0;
      rsp_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      rd_q          <= rd_d;
      rr_q          <= rr_d;
      ptr_q         <= ptr_d;
      mode_q        <= mode_d;
      wdata_q       <= wdata_d;
      eff_q         <= eff_d;
      newp_q        <= newp_d;
      rsp_rd_data_q <= rsp_rd_data_d;
      rsp_rr_data_q <= rsp_rr_data_d;
      rsp_addr_q    <= rsp_addr_d;
    end
  end

endmodule

// File: tb/tb_reg_file_sequencer.sv
// Self-checking bench for reg_file_sequencer: a bench-owned register file,
// a transaction-level reference model of register contents and responses,
// directed cases with literal expectations, then randomized requests.
module tb_reg_file_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [4:0]  req_rd;
  logic [4:0]  req_rr;
  logic [1:0]  req_ptr;
  logic [1:0]  req_ptr_mode;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rd_data;
  logic [7:0]  rsp_rr_data;
  logic [15:0] rsp_addr;
  logic        busy;
  logic [4:0]  rd_addr;
  logic [4:0]  rr_addr;
  logic [7:0]  rd_wdata;
  logic [7:0]  rr_wdata;
  logic [7:0]  rd_rdata;
  logic [7:0]  rr_rdata;
  logic        rd_cs;
  logic        rr_cs;
  logic        rd_we;
  logic        rr_we;

  logic [7:0]  rf [32];
  logic [7:0]  ref_rf [32];
  logic        pre_we;
  logic [4:0]  pre_addr;
  logic [7:0]  pre_data;

  logic [7:0]  exp_rd;
  logic [7:0]  exp_rr;
  logic [15:0] exp_addr;

  int          checks;
  int          errors;

  logic [32:0] ctrl_s;
  logic [31:0] rsp_s;

  localparam logic [4:0] Z5 = 5'd0;
  localparam logic [7:0] Z8 = 8'd0;

  reg_file_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_rd       (req_rd),
    .req_rr       (req_rr),
    .req_ptr      (req_ptr),
    .req_ptr_mode (req_ptr_mode),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rd_data  (rsp_rd_data),
    .rsp_rr_data  (rsp_rr_data),
    .rsp_addr     (rsp_addr),
    .busy         (busy),
    .rd_addr      (rd_addr),
    .rr_addr      (rr_addr),
    .rd_wdata     (rd_wdata),
    .rr_wdata     (rr_wdata),
    .rd_rdata     (rd_rdata),
    .rr_rdata     (rr_rdata),
    .rd_cs        (rd_cs),
    .rr_cs        (rr_cs),
    .rd_we        (rd_we),
    .rr_we        (rr_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: combinational read, write on rising edge with cs & we.
  assign rd_rdata = rf[rd_addr];
  assign rr_rdata = rf[rr_addr];
  always @(posedge clk) begin
    if (rd_cs && rd_we) rf[rd_addr] <= rd_wdata;
    if (rr_cs && rr_we) rf[rr_addr] <= rr_wdata;
    if (pre_we)         rf[pre_addr] <= pre_data;
  end

  assign ctrl_s = {busy, req_ready, rsp_valid, rd_cs, rd_we, rr_cs, rr_we,
                   rd_addr, rr_addr, rd_wdata, rr_wdata};
  assign rsp_s  = {rsp_rd_data, rsp_rr_data, rsp_addr};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Advance to the next falling edge and compare one cycle of outputs.
  task automatic cyc(input string nm, input logic b, input logic r, input logic v,
                     input logic dcs, input logic dwe, input logic rcs, input logic rwe,
                     input logic [4:0] da, input logic [4:0] ra,
                     input logic [7:0] dw, input logic [7:0] rw);
    @(negedge clk);
    chk({nm, "_ctl"}, 64'(ctrl_s), 64'({b, r, v, dcs, dwe, rcs, rwe, da, ra, dw, rw}));
    chk({nm, "_rsp"}, 64'(rsp_s), 64'({exp_rd, exp_rr, exp_addr}));
  endtask

  task automatic chk_rf(input string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < 32; i++) if (rf[i] !== ref_rf[i]) bad++;
    chk(nm, 64'(bad), 64'd0);
  endtask

  task automatic pre(input logic [4:0] a, input logic [7:0] dt);
    pre_we    = 1'b1;
    pre_addr  = a;
    pre_data  = dt;
    ref_rf[a] = dt;
    @(negedge clk);
    pre_we    = 1'b0;
  endtask

  task automatic drive(input logic [2:0] op, input logic [4:0] d, input logic [4:0] r,
                       input logic [1:0] s, input logic [1:0] m, input logic [15:0] w);
    req_valid    = 1'b1;
    req_op       = op;
    req_rd       = d;
    req_rr       = r;
    req_ptr      = s;
    req_ptr_mode = m;
    req_wdata    = w;
    @(posedge clk);
    #1;
    // Scramble fields after accept: the DUT must work from its latched copy.
    req_valid    = 1'b0;
    req_op       = 3'($urandom);
    req_rd       = 5'($urandom);
    req_rr       = 5'($urandom);
    req_ptr      = 2'($urandom);
    req_ptr_mode = 2'($urandom);
    req_wdata    = 16'($urandom);
  endtask

  // One full request, called at a falling edge while the DUT is idle.
  task automatic do_req(input logic [2:0] op, input logic [4:0] d, input logic [4:0] r,
                        input logic [1:0] s, input logic [1:0] m, input logic [15:0] w);
    logic [4:0]  a;
    logic [4:0]  lo;
    logic [15:0] p;
    logic [15:0] np;
    drive(op, d, r, s, m, w);
    case (op)
      3'd1: begin
        cyc("read", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, d, r, Z8, Z8);
        exp_rd = ref_rf[d];
        exp_rr = ref_rf[r];
      end
      3'd2: begin
        cyc("wbyte", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, d, Z5, w[7:0], Z8);
        ref_rf[d] = w[7:0];
      end
      3'd3: begin
        a = d & 5'b11110;
        cyc("wword", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, a, a + 5'd1, w[7:0], w[15:8]);
        ref_rf[a]        = w[7:0];
        ref_rf[a + 5'd1] = w[15:8];
      end
      3'd4: begin
        if (s < 2'd3) begin
          lo = 5'd26 + 5'(2 * int'(s));
          p  = {ref_rf[lo + 5'd1], ref_rf[lo]};
          cyc("ptr_rd", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, lo, lo + 5'd1, Z8, Z8);
          if (m == 2'd1 || m == 2'd2) begin
            np = (m == 2'd1) ? p + 16'd1 : p - 16'd1;
            cyc("ptr_wb", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, lo, lo + 5'd1, np[7:0], np[15:8]);
            ref_rf[lo]        = np[7:0];
            ref_rf[lo + 5'd1] = np[15:8];
          end
          exp_addr = (m == 2'd2) ? p - 16'd1 : p;
        end else begin
          exp_addr = 16'd0;
        end
      end
      default: begin
      end
    endcase
    cyc("done", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, Z5, Z5, Z8, Z8);
    cyc("idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z5, Z5, Z8, Z8);
    chk_rf("rf_contents");
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_op       = 3'd0;
    req_rd       = 5'd0;
    req_rr       = 5'd0;
    req_ptr      = 2'd0;
    req_ptr_mode = 2'd0;
    req_wdata    = 16'd0;
    pre_we       = 1'b0;
    pre_addr     = 5'd0;
    pre_data     = 8'd0;
    exp_rd       = 8'd0;
    exp_rr       = 8'd0;
    exp_addr     = 16'd0;

    #3;
    chk("reset_ctl", 64'(ctrl_s), 64'({1'b0, 1'b1, 31'd0}));
    chk("reset_rsp", 64'(rsp_s), 64'd0);

    // Fill the register file while still in reset; a request is offered too
    // and must not be taken.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'd1;
    for (int i = 0; i < 32; i++) pre(5'(i), 8'($urandom));
    req_valid = 1'b0;
    chk("reset_no_accept", 64'(ctrl_s), 64'({1'b0, 1'b1, 31'd0}));
    rst_n = 1'b1;
    cyc("idle0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z5, Z5, Z8, Z8);

    // Directed cases with literal expectations.
    pre(5'd5, 8'h3C);
    pre(5'd17, 8'hA5);
    do_req(3'd1, 5'd5, 5'd17, 2'd0, 2'd0, 16'd0);
    chk("pin_read_rd", 64'(rsp_rd_data), 64'h3C);
    chk("pin_read_rr", 64'(rsp_rr_data), 64'hA5);

    do_req(3'd3, 5'd25, 5'd0, 2'd0, 2'd0, 16'h1234);
    chk("pin_ww_r24", 64'(rf[24]), 64'h34);
    chk("pin_ww_r25", 64'(rf[25]), 64'h12);

    pre(5'd4, 8'h77);
    do_req(3'd2, 5'd3, 5'd0, 2'd0, 2'd0, 16'h00AB);
    chk("pin_wb_r3", 64'(rf[3]), 64'hAB);
    chk("pin_wb_r4", 64'(rf[4]), 64'h77);

    pre(5'd30, 8'hFF);
    pre(5'd31, 8'hFF);
    do_req(3'd4, 5'd0, 5'd0, 2'd2, 2'd1, 16'd0);
    chk("pin_zinc_addr", 64'(rsp_addr), 64'hFFFF);
    chk("pin_zinc_z", 64'({rf[31], rf[30]}), 64'h0000);

    pre(5'd26, 8'h00);
    pre(5'd27, 8'h00);
    do_req(3'd4, 5'd0, 5'd0, 2'd0, 2'd2, 16'd0);
    chk("pin_xdec_addr", 64'(rsp_addr), 64'hFFFF);
    chk("pin_xdec_x", 64'({rf[27], rf[26]}), 64'hFFFF);

    pre(5'd28, 8'h34);
    pre(5'd29, 8'h12);
    do_req(3'd4, 5'd0, 5'd0, 2'd1, 2'd0, 16'd0);
    chk("pin_yplain_addr", 64'(rsp_addr), 64'h1234);

    do_req(3'd4, 5'd0, 5'd0, 2'd3, 2'd1, 16'd0);
    chk("pin_sel3_addr", 64'(rsp_addr), 64'h0000);

    do_req(3'd6, 5'd9, 5'd10, 2'd0, 2'd0, 16'hBEEF);

    // Reset during PTR_WB: controls drop at once and the write is lost.
    drive(3'd4, 5'd0, 5'd0, 2'd0, 2'd1, 16'd0);
    cyc("rst_ptr_rd", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd26, 5'd27, Z8, Z8);
    cyc("rst_ptr_wb", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd26, 5'd27, 8'h00, 8'h00);
    #1;
    rst_n = 1'b0;
    #1;
    exp_rd   = 8'd0;
    exp_rr   = 8'd0;
    exp_addr = 16'd0;
    chk("rst_mid_ctl", 64'(ctrl_s), 64'({1'b0, 1'b1, 31'd0}));
    chk("rst_mid_rsp", 64'(rsp_s), 64'd0);
    @(negedge clk);
    chk("rst_hold_ctl", 64'(ctrl_s), 64'({1'b0, 1'b1, 31'd0}));
    chk("rst_ptr_kept", 64'({rf[27], rf[26]}), 64'hFFFF);
    chk_rf("rst_rf_contents");
    rst_n = 1'b1;
    cyc("post_rst_idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z5, Z5, Z8, Z8);
    do_req(3'd1, 5'd26, 5'd27, 2'd0, 2'd0, 16'd0);
    chk("post_rst_read", 64'({rsp_rd_data, rsp_rr_data}), 64'hFFFF);

    // Randomized requests against the model.
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 2))
        cyc("gap", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z5, Z5, Z8, Z8);
      do_req(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom),
             2'($urandom), 2'($urandom), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_sequencer.md
# reg_file_sequencer

Multi-cycle register-file access sequencer sitting between the decode/control stage and the dual-port register file. It accepts one request at a time over a valid/ready handshake and performs register-pair reads, byte or word writebacks, and pointer-pair fetch with optional post-increment or pre-decrement write-back. It generalises pointer selection to `PTR_COUNT` pairs and replaces undriven/`x` register-file controls with fully defined outputs.

## Interface
- `DATA_WIDTH`, 8, register width
- `R_ADDR_WIDTH`, 5, register address width (32 registers)
- `PTR_COUNT`, 3, number of pointer pairs (X, Y, Z)
- `PTR_BASE`, 26, address of low byte of pointer pair 0; pair n low = `PTR_BASE+2n`, high = `+1`
- `PTR_SEL_WIDTH`, 2, width of pointer select
- `clk` in 1: the single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1; `req_ready` out 1: request handshake; transfer on the rising edge where both are 1.
- `req_op` in 3: 0 NOP, 1 READ, 2 WRITE_BYTE, 3 WRITE_WORD, 4 PTR; 5-7 execute as NOP.
- `req_rd`, `req_rr` in `R_ADDR_WIDTH`: register operands.
- `req_ptr` in `PTR_SEL_WIDTH`: pointer pair select.
- `req_ptr_mode` in 2: 0 plain, 1 post-increment, 2 pre-decrement, 3 executes as plain.
- `req_wdata` in `2*DATA_WIDTH`: write data; low byte to Rd, high byte to Rd+1.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rd_data`, `rsp_rr_data` out `DATA_WIDTH`: READ results, held until the next completion.
- `rsp_addr` out `2*DATA_WIDTH`: effective pointer for PTR, held until the next completion.
- `busy` out 1: state is not IDLE.
- `rd_addr`, `rr_addr` out `R_ADDR_WIDTH`; `rd_wdata`, `rr_wdata` out `DATA_WIDTH`; `rd_rdata`, `rr_rdata` in `DATA_WIDTH`; `rd_cs`, `rr_cs`, `rd_we`, `rr_we` out 1: register-file ports.
  - Register file reads combinationally and writes on the rising edge when cs=1 and we=1.

## Operation
- Request latching:
  - In IDLE, `req_ready`=1. On accept, all `req_*` fields are latched; later input changes have no effect.
  - `req_ready`=0 in every other state.
- States: IDLE, READ, WRITE, PTR_RD, PTR_WB, DONE.
- IDLE transitions on accept:
  - NOP → DONE
  - READ → READ
  - WRITE_BYTE/WRITE_WORD → WRITE
  - PTR → PTR_RD, or → DONE with `rsp_addr`=0 and no register-file access if `req_ptr >= PTR_COUNT`.
- READ:
  - Drives `rd_addr`=Rd, `rr_addr`=Rr, both cs=1, we=0.
  - Captures `rd_rdata`/`rr_rdata` into `rsp_*_data` at the end of the cycle, then → DONE.
- WRITE:
  - WRITE_BYTE: rd port only, `rd_addr`=Rd, `rd_wdata`=wdata[7:0], cs=1, we=1; rr port idle.
  - WRITE_WORD: `rd_addr`=Rd with bit0 forced 0, `rr_addr`=that address+1, `rd_wdata`=wdata low byte, `rr_wdata`=wdata high byte, both we=1.
  - → DONE.
- PTR_RD:
  - Reads pair low on the rd port and pair high on the rr port.
  - Latches p = {high, low}.
  - Computes effective address: p-1 for pre-decrement, otherwise p.
  - Computes new pointer: p+1 for post-increment, p-1 for pre-decrement.
  - Arithmetic is modulo 2^(2*`DATA_WIDTH`): 0x0000-1 = 0xFFFF; 0xFFFF+1 = 0x0000.
  - Transitions: → PTR_WB if mode is 1 or 2, else → DONE.
- PTR_WB: writes new pointer low/high to the pair registers on both ports, then → DONE.
- DONE: `rsp_valid`=1 for this cycle, `rsp_addr` updated (PTR only), then → IDLE.
- Port controls when not accessing: all cs=0, we=0, addr=0, wdata=0. Never `x` or `z`.
- Reset (asynchronous):
  - State → IDLE; `rsp_valid`=0; `rsp_rd_data`=`rsp_rr_data`=`rsp_addr`=0; `busy`=0; all port controls 0.
  - Register-file outputs are decoded from state, so cs/we drop immediately on `rst_n` fall.
  - An in-flight write is aborted and no completion is produced.
  - `req_ready` reads 1, but no request is accepted while `rst_n`=0.

## Timing
- Accept edge T (state enters next on T):
  - READ/WRITE/NOP-via-WRITE: access cycle T..T+1, `rsp_valid` T+1..T+2; 2 cycles to completion, 3 cycles per request including IDLE.
  - NOP: `rsp_valid` cycle after accept.
  - PTR plain: 2 cycles to completion.
  - PTR inc/dec: 3 cycles to completion.
- Writes commit on the edge that ends WRITE/PTR_WB; DONE observers see updated register contents.
- No request overlap: a new accept is earliest on the edge ending the DONE+IDLE cycle.

## Test plan
- Reset: assert `rst_n`=0 mid-sequence → every output 0 except `req_ready`=1, no further RF writes; release → first request behaves normally.
- READ Rd=5, Rr=17 with RF r5=0x3C, r17=0xA5 → READ cycle has addr 5/17, cs=1, we=0; `rsp_valid` next cycle with 0x3C/0xA5.
- WRITE_WORD Rd=25, wdata=0x1234 → r24=0x34, r25=0x12, completes in 2 cycles; WRITE_BYTE Rd=3, 0x00AB → r3=0xAB only, rr_cs=0.
- PTR sel=2 (Z) post-inc, r30/r31=0xFF/0xFF → `rsp_addr`=0xFFFF, Z=0x0000 afterward; sel=0 pre-dec, X=0x0000 → `rsp_addr`=0xFFFF, X=0xFFFF.
- PTR sel=1 plain, Y=0x1234 → `rsp_addr`=0x1234, no write cycle, 2-cycle completion; sel=3 → `rsp_addr`=0, no RF activity.
- Assert `rst_n` low during PTR_WB → cs/we drop in the same cycle, pointer registers unchanged, no `rsp_valid`.
